// File: rtl/baud_cfg_pkg.sv
// Shared types and constants for the baud-rate reconfiguration sequencer:
// rate-select encoding, divisor table for a 50 MHz clock, and the sequencer
// state encoding.
package baud_cfg_pkg;

  typedef enum logic [1:0] {
    RATE_4800  = 2'd0,
    RATE_9600  = 2'd1,
    RATE_19200 = 2'd2,
    RATE_38400 = 2'd3
  } rate_sel_e;

  localparam logic [15:0] DIV_4800  = 16'd651;
  localparam logic [15:0] DIV_9600  = 16'd326;
  localparam logic [15:0] DIV_19200 = 16'd163;
  localparam logic [15:0] DIV_38400 = 16'd81;

  // Smallest divisor the generator can run with; anything below is rejected.
  localparam logic [15:0] MIN_DIVISOR = 16'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    WR_LO  = 3'd2,
    WR_HI  = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } cfg_state_e;

  function automatic logic [15:0] rate_to_divisor(input rate_sel_e sel);
    case (sel)
      RATE_4800:  return DIV_4800;
      RATE_9600:  return DIV_9600;
      RATE_19200: return DIV_19200;
      RATE_38400: return DIV_38400;
      default:    return DIV_9600;
    endcase
  endfunction

endpackage

// File: rtl/baud_cfg_ctrl.sv
// Baud generator reconfiguration sequencer. Resolves a rate code or raw
// divisor, holds off the link until TX/RX are idle, writes DB low then DB
// high, waits a short settle period and acknowledges the requester.
// Optional feature macro: BAUD_CFG_TIMEOUT_EN (bounded DRAIN wait with a
// sticky cfg_timeout flag); without it DRAIN waits indefinitely.
module baud_cfg_ctrl
  import baud_cfg_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd326,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic        cfg_raw,
  input  logic [1:0]  cfg_rate_sel,
  input  logic [15:0] cfg_divisor,
  input  logic        tx_busy,
  input  logic        rx_busy,
  output logic        cfg_busy,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic        cfg_timeout,
  output logic        link_hold,
  output logic        baud_write_en,
  output logic        baud_write_location,
  output logic [7:0]  baud_generator_write_line,
  output logic [15:0] cur_divisor
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  cfg_state_e  state_q, state_d;
  logic [15:0] target_q, target_d;
  logic [15:0] cur_q, cur_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [15:0] req_div;

`ifdef BAUD_CFG_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cur_q     <= DEFAULT_DIVISOR;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      settle_q  <= '0;
`ifdef BAUD_CFG_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_q     <= cur_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      settle_q  <= settle_d;
`ifdef BAUD_CFG_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Next-state logic: request acceptance, drain wait, write sequence, settle.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cur_d     = cur_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    settle_d  = settle_q;
`ifdef BAUD_CFG_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    req_div   = cfg_raw ? cfg_divisor : rate_to_divisor(rate_sel_e'(cfg_rate_sel));

    case (state_q)
      IDLE: begin
        if (cfg_req) begin
          target_d  = req_div;
          timeout_d = 1'b0;
          if (req_div < MIN_DIVISOR) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = DRAIN;
`ifdef BAUD_CFG_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      DRAIN: begin
        if (!tx_busy && !rx_busy) begin
          state_d = WR_LO;
        end
`ifdef BAUD_CFG_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = WR_LO;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      WR_LO: begin
        state_d = WR_HI;
      end
      WR_HI: begin
        cur_d    = target_q;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state and data only.
  always_comb begin
    cfg_busy                  = (state_q != IDLE);
    cfg_ack                   = 1'b0;
    cfg_err                   = 1'b0;
    link_hold                 = 1'b0;
    baud_write_en             = 1'b0;
    baud_write_location       = 1'b0;
    baud_generator_write_line = '0;
    case (state_q)
      DRAIN: begin
        link_hold = 1'b1;
      end
      WR_LO: begin
        link_hold                 = 1'b1;
        baud_write_en             = 1'b1;
        baud_generator_write_line = target_q[7:0];
      end
      WR_HI: begin
        link_hold                 = 1'b1;
        baud_write_en             = 1'b1;
        baud_write_location       = 1'b1;
        baud_generator_write_line = target_q[15:8];
      end
      SETTLE: begin
        link_hold = 1'b1;
      end
      DONE: begin
        cfg_ack = 1'b1;
        cfg_err = err_q;
      end
      default: begin
      end
    endcase
  end

  assign cur_divisor = cur_q;
  assign cfg_timeout = timeout_q;

endmodule
